// File: rtl/uart_tx_driver.sv
// 8N1 UART transmitter (LSB first, idle high) fed by a small power-of-two byte FIFO.
// Back-to-back queued bytes are sent with no idle gap between the stop bit and the next start bit.
module uart_tx_driver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                               HCLK,
    input  logic                               HRESET,
    input  logic [7:0]                         wdata,
    input  logic                               wvalid,
    output logic                               wready,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(CLKS_PER_BIT);

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;

    logic [1:0]    state_reg;
    logic [PW-1:0] prescale_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;

    logic          push;
    logic          pop;
    logic          fifo_nonempty;
    logic          bit_end;
    logic          stop_last;
    logic [7:0]    head;

    assign wready        = (level_reg != LEVEL_FULL);
    assign fifo_nonempty = (level_reg != '0);
    assign push          = wvalid & wready;
    assign bit_end       = (prescale_reg == PRE_LAST);
    assign stop_last     = (bit_cnt_reg == STOP_LAST);
    assign head          = mem[rd_ptr_reg];

    // A pop happens either from idle or exactly at the end of the last stop bit,
    // which is what lets queued frames run back to back.
    assign pop = fifo_nonempty &
                 ((state_reg == IDLE) |
                  ((state_reg == STOP) & bit_end & stop_last));

    assign tx         = tx_reg;
    assign fifo_level = level_reg;
    assign busy       = (state_reg != IDLE) | fifo_nonempty;

    always_ff @(posedge HCLK) begin
        if (push && !HRESET) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg    <= IDLE;
            prescale_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    prescale_reg <= '0;
                    tx_reg       <= 1'b1;
                    if (pop) begin
                        shift_reg   <= head;
                        tx_reg      <= 1'b0;
                        bit_cnt_reg <= '0;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        prescale_reg <= '0;
                        tx_reg       <= shift_reg[0];
                        state_reg    <= DATA;
                    end else begin
                        prescale_reg <= prescale_reg + PW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        prescale_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
                            tx_reg      <= 1'b1;
                            bit_cnt_reg <= '0;
                            state_reg   <= STOP;
                        end else begin
                            tx_reg      <= shift_reg[1];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        prescale_reg <= prescale_reg + PW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        prescale_reg <= '0;
                        if (stop_last) begin
                            bit_cnt_reg <= '0;
                            if (pop) begin
                                shift_reg <= head;
                                tx_reg    <= 1'b0;
                                state_reg <= START;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        prescale_reg <= prescale_reg + PW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_driver.sv
// Directed bench for uart_tx_driver: a default instance (16 clk/bit, 1 stop) and a
// fast instance (2 clk/bit, 2 stop bits) share the clock and reset.
module tb_uart_tx_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic       wvalid = 1'b0;
    logic       wready, tx, busy;
    logic [2:0] level;
    logic [7:0] wdata2 = 8'h00;
    logic       wvalid2 = 1'b0;
    logic       wready2, tx2, busy2;
    logic [2:0] level2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_driver dut (
        .HCLK(clk), .HRESET(rst), .wdata(wdata), .wvalid(wvalid),
        .wready(wready), .tx(tx), .busy(busy), .fifo_level(level)
    );

    uart_tx_driver #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .HCLK(clk), .HRESET(rst), .wdata(wdata2), .wvalid(wvalid2),
        .wready(wready2), .tx(tx2), .busy(busy2), .fifo_level(level2)
    );

    // Called on the negedge right after tx falls; returns on the negedge of the
    // last cycle of the frame. Every cycle is sampled; one comparison per bit.
    task automatic check_frame(input int sel, input logic [7:0] b, input int cpb,
                               input int stopb, input string name);
        for (int k = 0; k < 9 + stopb; k++) begin
            logic exp_bit;
            int   bad;
            exp_bit = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : 1'b1;
            bad = 0;
            for (int j = 0; j < cpb; j++) begin
                if (!(k == 0 && j == 0)) @(negedge clk);
                if (sel == 0) begin
                    if (tx !== exp_bit || busy !== 1'b1) bad++;
                end else begin
                    if (tx2 !== exp_bit || busy2 !== 1'b1) bad++;
                end
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL %s byte %h bit %0d: %0d bad cycles, required tx=%0b busy=1",
                         name, b, k, bad, exp_bit);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests += 6;
        if (tx !== 1'b1)     begin fails++; $display("FAIL reset_tx: got %b need 1", tx); end
        if (wready !== 1'b1) begin fails++; $display("FAIL reset_wready: got %b need 1", wready); end
        if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b need 0", busy); end
        if (level !== 3'd0)  begin fails++; $display("FAIL reset_level: got %0d need 0", level); end
        if (tx2 !== 1'b1)    begin fails++; $display("FAIL reset_tx2: got %b need 1", tx2); end
        if (busy2 !== 1'b0)  begin fails++; $display("FAIL reset_busy2: got %b need 0", busy2); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        wvalid = 1'b1; wdata = 8'h41;
        @(negedge clk);
        wvalid = 1'b0;
        tests += 2;
        if (level !== 3'd1) begin fails++; $display("FAIL single_level_e0: got %0d need 1", level); end
        if (tx !== 1'b1)    begin fails++; $display("FAIL single_tx_e0: got %b need 1", tx); end
        @(negedge clk);
        tests++;
        if (level !== 3'd0) begin fails++; $display("FAIL single_level_e1: got %0d need 0", level); end
        check_frame(0, 8'h41, 16, 1, "single");
        @(negedge clk);
        tests += 2;
        if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b need 0", busy); end
        if (tx !== 1'b1)   begin fails++; $display("FAIL single_tx_end: got %b need 1", tx); end
        $display("[TB] single 0x41 frame done");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wvalid = 1'b1; wdata = 8'h48;
        @(negedge clk);
        wdata = 8'h69;
        @(negedge clk);
        wvalid = 1'b0;
        check_frame(0, 8'h48, 16, 1, "b2b_first");
        @(negedge clk);
        check_frame(0, 8'h69, 16, 1, "b2b_second");
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b need 0", busy); end
        $display("[TB] back-to-back 0x48 0x69 done");
    endtask

    task automatic test_fifo_full();
        logic [7:0] bytes [6];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        @(negedge clk);
        tests++;
        if (wready !== 1'b1) begin fails++; $display("FAIL full_wready_0: got %b need 1", wready); end
        wvalid = 1'b1; wdata = bytes[0];
        @(negedge clk);
        tests++;
        if (wready !== 1'b1) begin fails++; $display("FAIL full_wready_1: got %b need 1", wready); end
        wdata = bytes[1];
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i != 0) @(negedge clk);
                    check_frame(0, bytes[i], 16, 1, "full_order");
                end
            end
            begin
                int waited;
                for (int i = 2; i < 5; i++) begin
                    tests++;
                    if (wready !== 1'b1) begin
                        fails++; $display("FAIL full_wready_%0d: got %b need 1", i, wready);
                    end
                    wdata = bytes[i];
                    @(negedge clk);
                end
                tests += 2;
                if (wready !== 1'b0) begin fails++; $display("FAIL full_wready_5: got %b need 0", wready); end
                if (level !== 3'd4)  begin fails++; $display("FAIL full_level: got %0d need 4", level); end
                wdata = bytes[5];
                waited = 0;
                while (wready !== 1'b1 && waited < 300) begin
                    @(negedge clk);
                    waited++;
                end
                tests++;
                if (waited != 157) begin
                    fails++; $display("FAIL full_readmit_delay: got %0d need 157", waited);
                end
                @(negedge clk);
                wvalid = 1'b0;
                tests++;
                if (level !== 3'd4) begin fails++; $display("FAIL full_level_refill: got %0d need 4", level); end
            end
        join
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_end: got %b need 0", busy); end
        $display("[TB] six-push FIFO full sequence done");
    endtask

    task automatic test_reset_midframe();
        int lows;
        @(negedge clk);
        wvalid = 1'b1; wdata = 8'hA1;
        @(negedge clk);
        wdata = 8'hB2;
        @(negedge clk);
        tests++;
        if (tx !== 1'b0) begin fails++; $display("FAIL rst_start: got %b need 0", tx); end
        wdata = 8'hC3;
        @(negedge clk);
        wvalid = 1'b0;
        tests++;
        if (level !== 3'd2) begin fails++; $display("FAIL rst_queued: got %0d need 2", level); end
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests += 4;
        if (tx !== 1'b1)     begin fails++; $display("FAIL rst_tx: got %b need 1", tx); end
        if (level !== 3'd0)  begin fails++; $display("FAIL rst_level: got %0d need 0", level); end
        if (busy !== 1'b0)   begin fails++; $display("FAIL rst_busy: got %b need 0", busy); end
        if (wready !== 1'b1) begin fails++; $display("FAIL rst_wready: got %b need 1", wready); end
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        tests++;
        if (lows != 0) begin fails++; $display("FAIL rst_quiet: got %0d active cycles need 0", lows); end
        $display("[TB] mid-frame reset done");
    endtask

    task automatic test_fast_two_stop();
        @(negedge clk);
        wvalid2 = 1'b1; wdata2 = 8'hFF;
        @(negedge clk);
        wdata2 = 8'h00;
        @(negedge clk);
        wvalid2 = 1'b0;
        check_frame(1, 8'hFF, 2, 2, "fast_ff");
        @(negedge clk);
        check_frame(1, 8'h00, 2, 2, "fast_00");
        @(negedge clk);
        tests += 2;
        if (busy2 !== 1'b0) begin fails++; $display("FAIL fast_busy_end: got %b need 0", busy2); end
        if (tx2 !== 1'b1)   begin fails++; $display("FAIL fast_tx_end: got %b need 1", tx2); end
        $display("[TB] 2 clk/bit, 2 stop bits 0xFF 0x00 done");
    endtask

    task automatic test_push_pop_same();
        logic [7:0] bytes [4];
        bytes = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
        @(negedge clk);
        wvalid = 1'b1; wdata = bytes[0];
        @(negedge clk);
        wdata = bytes[1];
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    if (i != 0) @(negedge clk);
                    check_frame(0, bytes[i], 16, 1, "pushpop_order");
                end
            end
            begin
                wdata = bytes[2];
                @(negedge clk);
                wvalid = 1'b0;
                repeat (158) @(negedge clk);
                tests++;
                if (level !== 3'd2) begin fails++; $display("FAIL pushpop_pre: got %0d need 2", level); end
                wvalid = 1'b1; wdata = bytes[3];
                @(negedge clk);
                wvalid = 1'b0;
                tests += 2;
                if (level !== 3'd2) begin fails++; $display("FAIL pushpop_level: got %0d need 2", level); end
                if (tx !== 1'b0)    begin fails++; $display("FAIL pushpop_start: got %b need 0", tx); end
            end
        join
        @(negedge clk);
        tests += 2;
        if (busy !== 1'b0)  begin fails++; $display("FAIL pushpop_busy_end: got %b need 0", busy); end
        if (level !== 3'd0) begin fails++; $display("FAIL pushpop_level_end: got %0d need 0", level); end
        $display("[TB] same-cycle push/pop at stop->start done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_reset_midframe();
        test_fast_two_stop();
        test_push_pop_same();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
